// File: rtl/regfile_mp.sv
// Multi-port register file with per-register pending (busy) tracking.
// Register 0 is hardwired to zero and can never be pending. A reservation
// marks a register pending until it is next written; reserve beats write
// when both target the same register in the same cycle.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(NREGS)-1:0]   wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic                       rsv_en,
  input  logic [$clog2(NREGS)-1:0]   rsv_addr,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]        rd_data,
  output logic [NRD-1:0]             rd_busy,
  output logic [$clog2(NREGS):0]     busy_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(NREGS - 1);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;

  logic wr_hit;
  logic rsv_hit;
  logic same_reg;
  logic cnt_inc;
  logic cnt_dec;

  // Qualify strobes: index 0 and reset both suppress any state change.
  always_comb begin
    wr_hit   = wr_en && (wr_addr != '0) && !rst;
    rsv_hit  = rsv_en && (rsv_addr != '0) && !rst;
    same_reg = wr_hit && rsv_hit && (wr_addr == rsv_addr);
    cnt_inc  = rsv_hit && !busy[rsv_addr] && (busy_cnt != CNT_MAX);
    cnt_dec  = wr_hit && busy[wr_addr] && !same_reg && (busy_cnt != '0);
  end

  // Data storage; register 0 is never written so it stays at reset zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Busy bits: write clears, reserve sets, reserve applied last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_hit)  busy[wr_addr]  <= 1'b0;
      if (rsv_hit) busy[rsv_addr] <= 1'b1;
    end
  end

  // Pending counter moves by at most one per edge, mirroring the busy bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      busy_cnt <= busy_cnt + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  // Combinational read ports with optional same-cycle write forwarding.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] ra;
      logic          fwd;
      ra  = rd_addr[k*AW +: AW];
      fwd = (BYPASS != 0) && wr_hit && (wr_addr == ra);
      if (ra == '0) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end else if (fwd) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
        rd_busy[k]              = (rsv_hit && (rsv_addr == ra)) ? busy[ra] : 1'b0;
      end else begin
        rd_data[k*XLEN +: XLEN] = mem[ra];
        rd_busy[k]              = busy[ra];
      end
    end
  end

endmodule
